// File: rtl/dme_pkg.sv
// dme_pkg
// Shared definitions for the DME power sequencer: FSM state encoding
// (also exported on the DME_State debug port) and a helper that says which
// states are allowed to pass the synchronised power-good through.
package dme_pkg;

    localparam int DME_STATE_W = 3;

    typedef enum logic [DME_STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_PG = 3'd1,
        ST_PG_DLY  = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } dme_state_e;

    // Power-good is only reported downstream once the sequencer has seen it
    // and committed to powering up.
    function automatic logic pg_visible(input dme_state_e st);
        return (st == ST_PG_DLY) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/dme_sync_deb.sv
// dme_sync_deb
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// The debounced value changes only after DEB_CNT consecutive synced samples
// that disagree with it; any agreeing sample restarts the count.
// Ports:
//   clk    in  1  sampling clock
//   rst_n  in  1  async active-low reset; all flops load RST_VAL
//   raw    in  1  asynchronous input pin
//   deb    out 1  synchronised, debounced value (registered)
module dme_sync_deb #(
    parameter int   DEB_CNT = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int CNT_W = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            deb  <= RST_VAL;
            cnt  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // this is the DEB_CNT-th consecutive differing sample
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dme_pwr_seq.sv
// dme_pwr_seq
// Synchronises the DME presence / power-good pins and the PSU power-ok,
// debounces presence, and sequences DME power-up: wait for PG, hold off a
// settle delay, then declare ready. PG timeout or PG loss while running is
// latched as a fault until the supply or the card goes away.
// Ports:
//   CLK32768            in  1  system clock
//   ResetN              in  1  async active-low reset
//   PWRGD_PS_PWROK_3V3  in  1  PSU power ok (async)
//   DME_PRSNT_N_RAW     in  1  presence pin, low = present (async)
//   DME_PWRGD_RAW       in  1  DME power-good pin (async)
//   DME_Absent          out 1  debounced presence, 1 = absent
//   DME_PWRGD           out 1  synced PG, only in PG_DLY / RUN
//   DME_Rdy             out 1  high in RUN
//   DME_Fault           out 1  high in FAULT
//   DME_State           out 3  current FSM state (debug)
//
// state   | meaning
// IDLE    | supply off or card absent; waiting for both to be good
// WAIT_PG | powered, waiting for DME PG; times out after PG_TMO cycles
// PG_DLY  | PG seen; settling for PG_DLY cycles
// RUN     | DME ready
// FAULT   | PG timeout or PG lost in RUN; held until off
module dme_pwr_seq
    import dme_pkg::*;
#(
    parameter int DEB_CNT = 4,
    parameter int PG_DLY  = 100,
    parameter int PG_TMO  = 2000
) (
    input  logic                   CLK32768,
    input  logic                   ResetN,
    input  logic                   PWRGD_PS_PWROK_3V3,
    input  logic                   DME_PRSNT_N_RAW,
    input  logic                   DME_PWRGD_RAW,
    output logic                   DME_Absent,
    output logic                   DME_PWRGD,
    output logic                   DME_Rdy,
    output logic                   DME_Fault,
    output logic [DME_STATE_W-1:0] DME_State
);

    localparam int TMR_W = $clog2(PG_TMO);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(PG_TMO - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(PG_DLY - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    logic psok_meta, psok_s;
    logic pg_meta, pg_s;
    logic off;

    dme_state_e       state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;

    dme_sync_deb #(
        .DEB_CNT (DEB_CNT),
        .RST_VAL (1'b1)
    ) u_prsnt (
        .clk   (CLK32768),
        .rst_n (ResetN),
        .raw   (DME_PRSNT_N_RAW),
        .deb   (DME_Absent)
    );

    always_ff @(posedge CLK32768 or negedge ResetN) begin
        if (!ResetN) begin
            psok_meta <= 1'b0;
            psok_s    <= 1'b0;
            pg_meta   <= 1'b0;
            pg_s      <= 1'b0;
        end else begin
            psok_meta <= PWRGD_PS_PWROK_3V3;
            psok_s    <= psok_meta;
            pg_meta   <= DME_PWRGD_RAW;
            pg_s      <= pg_meta;
        end
    end

    assign off = !psok_s || DME_Absent;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            ST_IDLE: begin
                if (!off) state_nxt = ST_WAIT_PG;
            end
            ST_WAIT_PG: begin
                if (off)                    state_nxt = ST_IDLE;
                else if (pg_s)              state_nxt = ST_PG_DLY;
                else if (timer == TMO_LAST) state_nxt = ST_FAULT;
                else if (timer != TMR_MAX)  timer_nxt = timer + 1'b1;
            end
            ST_PG_DLY: begin
                if (off)                    state_nxt = ST_IDLE;
                else if (!pg_s)             state_nxt = ST_WAIT_PG;
                else if (timer == DLY_LAST) state_nxt = ST_RUN;
                else if (timer != TMR_MAX)  timer_nxt = timer + 1'b1;
            end
            ST_RUN: begin
                if (off)        state_nxt = ST_IDLE;
                else if (!pg_s) state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                if (off) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) timer_nxt = '0;
    end

    // Outputs are registered from the next-state values so they change on
    // the same edge as the state register. pg_meta is what pg_s becomes on
    // this edge.
    always_ff @(posedge CLK32768 or negedge ResetN) begin
        if (!ResetN) begin
            state     <= ST_IDLE;
            timer     <= '0;
            DME_PWRGD <= 1'b0;
            DME_Rdy   <= 1'b0;
            DME_Fault <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            DME_PWRGD <= pg_meta && pg_visible(state_nxt);
            DME_Rdy   <= (state_nxt == ST_RUN);
            DME_Fault <= (state_nxt == ST_FAULT);
        end
    end

    assign DME_State = state;

endmodule

// File: tb/tb_dme_pwr_seq.sv
module tb_dme_pwr_seq;

    localparam int DEB_CNT = 4;
    localparam int PG_DLY  = 8;
    localparam int PG_TMO  = 32;

    localparam int S_IDLE = 0, S_WAIT = 1, S_DLY = 2, S_RUN = 3, S_FAULT = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       psok    = 1'b0;
    logic       prsnt_n = 1'b1;
    logic       pg      = 1'b0;
    logic       absent, pwrgd, rdy, fault;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dme_pwr_seq #(
        .DEB_CNT (DEB_CNT),
        .PG_DLY  (PG_DLY),
        .PG_TMO  (PG_TMO)
    ) dut (
        .CLK32768           (clk),
        .ResetN             (rst_n),
        .PWRGD_PS_PWROK_3V3 (psok),
        .DME_PRSNT_N_RAW    (prsnt_n),
        .DME_PWRGD_RAW      (pg),
        .DME_Absent         (absent),
        .DME_PWRGD          (pwrgd),
        .DME_Rdy            (rdy),
        .DME_Fault          (fault),
        .DME_State          (state)
    );

    // Reference model: synced values as a two-sample delay line, debounce as
    // a history of "differs" flags since the last flip, FSM timing as the
    // number of edges elapsed since the edge that entered the current state.
    logic m_psok_d1, m_psok_s, m_prs_d1, m_prs_s, m_pg_d1, m_pg_s;
    logic m_absent;
    bit   diff_q[$];
    int   m_st, m_enter, m_edge;

    function automatic void model_reset();
        m_psok_d1 = 1'b0; m_psok_s = 1'b0;
        m_pg_d1   = 1'b0; m_pg_s   = 1'b0;
        m_prs_d1  = 1'b1; m_prs_s  = 1'b1;
        m_absent  = 1'b1;
        diff_q.delete();
        m_st = S_IDLE; m_enter = 0; m_edge = 0;
    endfunction

    function automatic void model_step();
        bit off;
        int held, nxt, ndiff;
        m_edge++;
        off  = !m_psok_s || m_absent;
        held = m_edge - m_enter;
        nxt  = m_st;
        case (m_st)
            S_IDLE:  if (!off) nxt = S_WAIT;
            S_WAIT:  if (off) nxt = S_IDLE; else if (m_pg_s) nxt = S_DLY;
                     else if (held == PG_TMO) nxt = S_FAULT;
            S_DLY:   if (off) nxt = S_IDLE; else if (!m_pg_s) nxt = S_WAIT;
                     else if (held == PG_DLY) nxt = S_RUN;
            S_RUN:   if (off) nxt = S_IDLE; else if (!m_pg_s) nxt = S_FAULT;
            default: if (off) nxt = S_IDLE;
        endcase
        if (nxt != m_st) begin
            m_st    = nxt;
            m_enter = m_edge;
        end
        diff_q.push_back(m_prs_s != m_absent);
        while (diff_q.size() > DEB_CNT) void'(diff_q.pop_front());
        ndiff = 0;
        foreach (diff_q[i]) if (diff_q[i]) ndiff++;
        if (ndiff == DEB_CNT) begin
            m_absent = !m_absent;
            diff_q.delete();
        end
        m_psok_s = m_psok_d1; m_psok_d1 = psok;
        m_prs_s  = m_prs_d1;  m_prs_d1  = prsnt_n;
        m_pg_s   = m_pg_d1;   m_pg_d1   = pg;
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_val("absent", {7'd0, absent}, {7'd0, m_absent});
        check_val("pwrgd",  {7'd0, pwrgd},  {7'd0, m_pg_s && (m_st == S_DLY || m_st == S_RUN)});
        check_val("rdy",    {7'd0, rdy},    {7'd0, m_st == S_RUN});
        check_val("fault",  {7'd0, fault},  {7'd0, m_st == S_FAULT});
        check_val("state",  {5'd0, state},  8'(m_st));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int abs_k, rdy_k, flt_k;
        bit seen_low, seen_fault;

        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // 1: present + PSOK, PG five cycles later
        psok = 1'b1; prsnt_n = 1'b0;
        abs_k = -1; rdy_k = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 5) pg = 1'b1;
            if (abs_k < 0 && !absent) abs_k = k;
            if (rdy_k < 0 && rdy) rdy_k = k;
        end
        check_val("abs_latency", 8'(abs_k), 8'(2 + DEB_CNT));
        check_val("rdy_latency", 8'(rdy_k), 8'(5 + 2 + 1 + PG_DLY));

        // 2: PG timeout, fault is sticky, PSOK drop clears it
        psok = 1'b0; pg = 1'b0;
        repeat (5) tick();
        psok = 1'b1;
        flt_k = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (flt_k < 0 && fault) flt_k = k;
        end
        check_val("tmo_latency", 8'(flt_k), 8'(3 + PG_TMO));
        pg = 1'b1;
        repeat (10) tick();
        check_val("fault_sticky", {7'd0, fault}, 8'd1);
        psok = 1'b0;
        repeat (3) tick();
        check_val("fault_clear", {7'd0, fault}, 8'd0);

        // 3: presence glitches
        prsnt_n = 1'b1;
        repeat (10) tick();
        prsnt_n = 1'b0;
        repeat (3) tick();
        prsnt_n = 1'b1;
        seen_low = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (!absent) seen_low = 1'b1;
        end
        check_val("glitch3_absent", {7'd0, seen_low}, 8'd0);
        prsnt_n = 1'b0;
        repeat (4) tick();
        prsnt_n = 1'b1;
        seen_low = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (!absent) seen_low = 1'b1;
        end
        check_val("glitch4_absent", {7'd0, seen_low}, 8'd1);

        // 4: PG loss in RUN -> FAULT; PG loss in PG_DLY -> restart delay
        psok = 1'b1; prsnt_n = 1'b0; pg = 1'b1;
        repeat (30) tick();
        check_val("run_reached", {7'd0, rdy}, 8'd1);
        pg = 1'b0;
        tick();
        pg = 1'b1;
        repeat (5) tick();
        check_val("run_pg_loss", {7'd0, fault}, 8'd1);
        psok = 1'b0;
        repeat (4) tick();
        psok = 1'b1;
        for (int k = 0; k < 20 && state != 3'(S_DLY); k++) tick();
        check_val("in_pg_dly", {5'd0, state}, 8'(S_DLY));
        repeat (3) tick();
        pg = 1'b0;
        tick();
        pg = 1'b1;
        rdy_k = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (rdy_k < 0 && rdy) rdy_k = k;
        end
        check_val("dly_restart", 8'(rdy_k), 8'(2 + 1 + PG_DLY));

        // 5: PSOK and PG drop together in RUN -> IDLE; reset mid PG_DLY
        psok = 1'b0; pg = 1'b0;
        seen_fault = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (fault) seen_fault = 1'b1;
        end
        check_val("off_beats_pg", {7'd0, seen_fault}, 8'd0);
        psok = 1'b1; pg = 1'b1;
        for (int k = 0; k < 20 && state != 3'(S_DLY); k++) tick();
        tick();
        do_reset();

        // 6: absent debounced high exactly at the timeout edge
        pg = 1'b0;
        for (int k = 0; k < 40 && m_st != S_WAIT; k++) tick();
        repeat (PG_TMO - 7) tick();
        prsnt_n = 1'b1;
        seen_fault = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (fault) seen_fault = 1'b1;
        end
        check_val("idle_beats_tmo", {7'd0, seen_fault}, 8'd0);

        // random traffic
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            if ($urandom_range(0, 39) == 0) do_reset();
            psok    = ($urandom_range(0, 7) != 0);
            prsnt_n = ($urandom_range(0, 5) == 0);
            pg      = ($urandom_range(0, 9) < 7);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 45);
            repeat (len) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
